// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: FSM states,
// command table (right-aligned, byte 0 in the MSBs) and response strings.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_GAP,
      S_PARSE,
      S_RESP,
      S_TXWAIT
   } state_t;

   localparam int STR_LEN = 6;
   localparam int CMD_MAX = 8;

   localparam logic [8*STR_LEN-1:0] PASS_STR = 48'h50_61_73_73_0D_0A;  // "Pass\r\n"
   localparam logic [8*STR_LEN-1:0] FAIL_STR = 48'h46_61_69_6C_0D_0A;  // "Fail\r\n"

   // Shorter commands compare against the low CMD_LENGTH bytes of each entry.
   localparam logic [63:0] CMD_TABLE [CMD_MAX] = '{
      64'h0000_0000_5445_5354,  // TEST
      64'h0000_0000_5354_4154,  // STAT
      64'h0000_0000_5253_4554,  // RSET
      64'h0000_0000_5645_5253,  // VERS
      64'h0000_0000_4845_4C50,  // HELP
      64'h0000_0000_5049_4E47,  // PING
      64'h0000_0000_5354_4F50,  // STOP
      64'h0000_0000_424F_4F54   // BOOT
   };

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// Serialises a 6-byte string into the TX FIFO, one push per cycle at most,
// with a mandatory idle cycle after every push and no push while full.
module uart_cmd_tx_seq
   import uart_cmd_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [8*STR_LEN-1:0]   str,
   input  logic                   tx_fifo_full,
   output logic [7:0]             data,
   output logic                   write_en,
   output logic                   done
);

   logic [8*STR_LEN-1:0] shreg;
   logic [2:0]           remaining;
   logic                 active;
   logic                 gap;

   assign write_en = active && (remaining != 3'd0) && !gap && !tx_fifo_full;
   assign data     = shreg[8*STR_LEN-1 -: 8];
   assign done     = active && (remaining == 3'd0) && !gap;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg     <= '0;
         remaining <= 3'd0;
         active    <= 1'b0;
         gap       <= 1'b0;
      end else if (start) begin
         shreg     <= str;
         remaining <= 3'(STR_LEN);
         active    <= 1'b1;
         gap       <= 1'b0;
      end else if (active) begin
         if (write_en) begin
            shreg     <= {shreg[8*STR_LEN-9:0], 8'h00};
            remaining <= remaining - 3'd1;
            gap       <= 1'b1;
         end else begin
            gap <= 1'b0;
         end
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Collects CMD_LENGTH bytes from the RX FIFO, matches them against CMD_TABLE
// and answers Pass/Fail on TX. Optional byte echo: UART_CMD_ECHO_EN.
//   state    | meaning
//   S_IDLE   | wait for RX byte; inter-byte timeout runs while idx != 0
//   S_POP    | pop one byte into cmd_buf[idx]
//   S_GAP    | no-pop cycle so rx_fifo_empty settles; report match on last byte
//   S_PARSE  | latched match result is visible on cmd_strobe/cmd_error
//   S_RESP   | launch the Pass/Fail string
//   S_TXWAIT | string draining into the TX FIFO
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 27000000,
   parameter int CMD_LENGTH      = 4,
   parameter int NUM_CMDS        = 4,
   parameter int TIMEOUT_US      = 10000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx_fifo_empty,
   input  logic [7:0] rx_fifo_data_out,
   output logic       rx_fifo_read_en,
   input  logic       tx_fifo_full,
   output logic [7:0] tx_fifo_data_in,
   output logic       tx_fifo_write_en,
   output logic       cmd_strobe,
   output logic [2:0] cmd_id,
   output logic       cmd_error
);

   localparam int         TMO_CYCLES = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
   localparam int         TMO_W      = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES + 1) : 1;
   localparam logic [2:0] IDX_LAST   = 3'(CMD_LENGTH - 1);

   state_t                  state, state_next;
   logic [2:0]              idx;
   logic [7:0]              cmd_buf [CMD_LENGTH];
   logic [TMO_W-1:0]        timer;
   logic [8*CMD_LENGTH-1:0] cmd_word;
   logic                    hit;
   logic [2:0]              hit_idx;
   logic                    resp_hit;
   logic                    last_byte;
   logic                    timeout;
   logic                    seq_start;
   logic                    seq_we;
   logic                    seq_done;
   logic [7:0]              seq_data;
   logic                    echo_block;

   always_comb begin
      cmd_word = '0;
      for (int i = 0; i < CMD_LENGTH; i++) cmd_word[(CMD_LENGTH-1-i)*8 +: 8] = cmd_buf[i];
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = 3'd0;
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
         if (cmd_word == CMD_TABLE[i][8*CMD_LENGTH-1:0]) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   assign last_byte       = (idx == IDX_LAST);
   assign timeout         = (state == S_IDLE) && (idx != 3'd0) && (timer == '0) && rx_fifo_empty;
   assign rx_fifo_read_en = (state == S_POP);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      seq_start  = 1'b0;
      case (state)
         S_IDLE:   if (!timeout && !rx_fifo_empty && !echo_block) state_next = S_POP;
         S_POP:    state_next = S_GAP;
         S_GAP:    state_next = last_byte ? S_PARSE : S_IDLE;
         S_PARSE:  state_next = S_RESP;
         S_RESP: begin
            if (!echo_block) begin
               seq_start  = 1'b1;
               state_next = S_TXWAIT;
            end
         end
         S_TXWAIT: if (seq_done) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx        <= 3'd0;
         timer      <= '0;
         cmd_id     <= 3'd0;
         cmd_strobe <= 1'b0;
         cmd_error  <= 1'b0;
         resp_hit   <= 1'b0;
         for (int i = 0; i < CMD_LENGTH; i++) cmd_buf[i] <= 8'h00;
      end else begin
         cmd_strobe <= 1'b0;
         cmd_error  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (timeout) begin
                  idx       <= 3'd0;
                  cmd_error <= 1'b1;
               end else if (idx != 3'd0 && timer != '0) begin
                  timer <= timer - TMO_W'(1);
               end
            end
            S_POP: begin
               for (int i = 0; i < CMD_LENGTH; i++)
                  if (idx == 3'(i)) cmd_buf[i] <= rx_fifo_data_out;
               timer <= TMO_W'(TMO_CYCLES - 1);
            end
            S_GAP: begin
               if (last_byte) begin
                  idx      <= 3'd0;
                  resp_hit <= hit;
                  if (hit) begin
                     cmd_strobe <= 1'b1;
                     cmd_id     <= hit_idx;
                  end else begin
                     cmd_error <= 1'b1;
                  end
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   uart_cmd_tx_seq u_tx_seq (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (seq_start),
      .str          (resp_hit ? PASS_STR : FAIL_STR),
      .tx_fifo_full (tx_fifo_full),
      .data         (seq_data),
      .write_en     (seq_we),
      .done         (seq_done)
   );

`ifdef UART_CMD_ECHO_EN
   // Echo is pushed from S_IDLE or S_RESP, where the sequencer is never active,
   // and holds off the next pop / the response launch until it is out.
   logic       echo_pend;
   logic [7:0] echo_byte;
   logic       echo_we;

   assign echo_we    = echo_pend && !tx_fifo_full && (state == S_IDLE || state == S_RESP);
   assign echo_block = echo_pend;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         echo_pend <= 1'b0;
         echo_byte <= 8'h00;
      end else if (state == S_POP) begin
         echo_pend <= 1'b1;
         echo_byte <= rx_fifo_data_out;
      end else if (echo_we) begin
         echo_pend <= 1'b0;
      end
   end

   assign tx_fifo_write_en = seq_we | echo_we;
   assign tx_fifo_data_in  = echo_we ? echo_byte : seq_data;
`else
   assign echo_block       = 1'b0;
   assign tx_fifo_write_en = seq_we;
   assign tx_fifo_data_in  = seq_data;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a show-ahead RX FIFO model and TX capture.
module tb_uart_cmd_parser;

   localparam logic [47:0] PASS = 48'h5061_7373_0D0A;
   localparam logic [47:0] FAIL_RESP = 48'h4661_696C_0D0A;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_fifo_empty = 1'b1;
   logic [7:0] rx_fifo_data_out = 8'h00;
   logic       tx_fifo_full = 1'b0;
   logic       rx_fifo_read_en;
   logic [7:0] tx_fifo_data_in;
   logic       tx_fifo_write_en;
   logic       cmd_strobe;
   logic [2:0] cmd_id;
   logic       cmd_error;

   always #5 clock = ~clock;

   uart_cmd_parser #(
      .CLOCK_FREQUENCY (1000000),
      .CMD_LENGTH      (4),
      .NUM_CMDS        (4),
      .TIMEOUT_US      (200)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .rx_fifo_empty    (rx_fifo_empty),
      .rx_fifo_data_out (rx_fifo_data_out),
      .rx_fifo_read_en  (rx_fifo_read_en),
      .tx_fifo_full     (tx_fifo_full),
      .tx_fifo_data_in  (tx_fifo_data_in),
      .tx_fifo_write_en (tx_fifo_write_en),
      .cmd_strobe       (cmd_strobe),
      .cmd_id           (cmd_id),
      .cmd_error        (cmd_error)
   );

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         last_pop = 0;
   int         strobe_cnt = 0;
   int         error_cnt = 0;
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic [2:0] id_log[$];
   logic       prev_rd = 1'b0;
   logic       prev_we = 1'b0;
   logic       pop_req = 1'b0;

   typedef struct {
      logic [31:0] word;
      logic        hit;
      logic [2:0]  id;
      logic [47:0] resp;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void rx_update();
      rx_fifo_empty    = (rxq.size() == 0);
      rx_fifo_data_out = rx_fifo_empty ? 8'h00 : rxq[0];
   endfunction

   // Outputs sampled on the falling edge, half a cycle away from the DUT edge.
   always @(negedge clock) begin
      cyc++;
      if (rx_fifo_read_en) begin
         check("rd_not_consecutive", 64'(prev_rd), 64'd0);
         check("rd_not_empty", 64'(rx_fifo_empty), 64'd0);
         last_pop = cyc;
         pop_req  = 1'b1;
      end
      if (tx_fifo_write_en) begin
         check("we_not_full", 64'(tx_fifo_full), 64'd0);
         check("we_gap", 64'(prev_we), 64'd0);
         txq.push_back(tx_fifo_data_in);
      end
      if (cmd_strobe || cmd_error) check("strobe_error_excl", 64'(cmd_strobe && cmd_error), 64'd0);
      if (cmd_strobe) begin
         strobe_cnt++;
         id_log.push_back(cmd_id);
         check("strobe_latency", 64'(cyc - last_pop), 64'd2);
      end
      if (cmd_error) error_cnt++;
      prev_rd = rx_fifo_read_en;
      prev_we = tx_fifo_write_en;
   end

   // Show-ahead FIFO: a pop seen during a cycle takes effect just after its closing edge.
   always @(posedge clock) begin
      if (pop_req) begin
         #1;
         if (rxq.size() > 0) void'(rxq.pop_front());
         pop_req = 1'b0;
         rx_update();
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) rxq.push_back(w[31-8*i -: 8]);
      rx_update();
   endtask

   task automatic wait_tx(input int n, input string name);
      int b = 0;
      while (txq.size() < n && b < 400) begin
         tick(1);
         b++;
      end
      if (txq.size() < n) begin
         checks++;
         failures++;
         $display("FAIL %s: timed out with %0d TX bytes, required %0d", name, txq.size(), n);
      end
   endtask

   function automatic logic [47:0] take6();
      logic [47:0] r = '0;
      for (int i = 0; i < 6; i++) if (txq.size() > 0) r = {r[39:0], txq.pop_front()};
      return r;
   endfunction

   task automatic run_cmd(input string name, input logic [31:0] w, input logic hit,
                          input logic [2:0] id, input logic [47:0] resp);
      int s0 = strobe_cnt;
      int e0 = error_cnt;
      push_word(w);
      wait_tx(6, {name, "_tx"});
      check({name, "_resp"}, 64'(take6()), 64'(resp));
      check({name, "_strobe"}, 64'(strobe_cnt - s0), 64'(hit));
      check({name, "_error"}, 64'(error_cnt - e0), 64'(!hit));
      if (hit) check({name, "_id"}, 64'(cmd_id), 64'(id));
      tick(4);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_rd"}, 64'(rx_fifo_read_en), 64'd0);
      check({name, "_we"}, 64'(tx_fifo_write_en), 64'd0);
      check({name, "_data"}, 64'(tx_fifo_data_in), 64'd0);
      check({name, "_strobe"}, 64'(cmd_strobe), 64'd0);
      check({name, "_id"}, 64'(cmd_id), 64'd0);
      check({name, "_error"}, 64'(cmd_error), 64'd0);
   endtask

   initial begin
      int s0, e0;
      vecs[0] = '{32'h5445_5354, 1'b1, 3'd0, PASS};       // TEST
      vecs[1] = '{32'h5354_4154, 1'b1, 3'd1, PASS};       // STAT
      vecs[2] = '{32'h5253_4554, 1'b1, 3'd2, PASS};       // RSET
      vecs[3] = '{32'h5645_5253, 1'b1, 3'd3, PASS};       // VERS
      vecs[4] = '{32'h4142_4344, 1'b0, 3'd0, FAIL_RESP};  // ABCD
      vecs[5] = '{32'h5445_5358, 1'b0, 3'd0, FAIL_RESP};  // TESX
      vecs[6] = '{32'h7465_7374, 1'b0, 3'd0, FAIL_RESP};  // test

      tick(3);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      tick(2);

      for (int i = 0; i < 7; i++)
         run_cmd($sformatf("vec%0d", i), vecs[i].word, vecs[i].hit, vecs[i].id, vecs[i].resp);

      // Partial command then silence: one error, no response, then normal operation.
      s0 = strobe_cnt;
      e0 = error_cnt;
      rxq.push_back(8'h54);
      rxq.push_back(8'h45);
      rx_update();
      tick(400);
      check("tmo_error", 64'(error_cnt - e0), 64'd1);
      check("tmo_strobe", 64'(strobe_cnt - s0), 64'd0);
      check("tmo_no_tx", 64'(txq.size()), 64'd0);
      run_cmd("after_tmo", 32'h5445_5354, 1'b1, 3'd0, PASS);

      // TX full held mid-response.
      push_word(32'h5445_5354);
      wait_tx(2, "full_pre");
      tx_fifo_full = 1'b1;
      tick(50);
      check("full_hold_count", 64'(txq.size()), 64'd2);
      tx_fifo_full = 1'b0;
      wait_tx(6, "full_post");
      check("full_resp", 64'(take6()), 64'(PASS));
      tick(4);

      // Two commands preloaded back to back.
      s0 = strobe_cnt;
      id_log.delete();
      push_word(32'h5445_5354);
      push_word(32'h5354_4154);
      wait_tx(12, "b2b_tx");
      check("b2b_strobes", 64'(strobe_cnt - s0), 64'd2);
      check("b2b_id0", 64'((id_log.size() > 0) ? id_log[0] : 3'd7), 64'd0);
      check("b2b_id1", 64'((id_log.size() > 1) ? id_log[1] : 3'd7), 64'd1);
      check("b2b_resp0", 64'(take6()), 64'(PASS));
      check("b2b_resp1", 64'(take6()), 64'(PASS));
      tick(4);

      // Reset after the third response byte abandons the response.
      push_word(32'h5645_5253);
      wait_tx(3, "rst_pre");
      check("rst_pre_id", 64'(cmd_id), 64'd3);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      tick(3);
      reset_n = 1'b1;
      tick(100);
      check("rst_no_residual", 64'(txq.size()), 64'd3);
      txq.delete();
      run_cmd("after_rst", 32'h5445_5354, 1'b1, 3'd0, PASS);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
